// File: rtl/rx_packet_parser.sv
// rx_packet_parser: byte-stream packet framer.
// Frame layout: SFD (SFD_BYTES) | type (2) | length L (1) | payload (L) | FCS (1).
// Payload is streamed out one cycle after it is consumed, without buffering.
// The FCS byte carries the two's complement of the 8-bit running sum of the
// type bytes, L and the payload, so a good frame makes (sum + FCS) == 0.
// Optional feature: define RX_PACKET_PARSER_ERR_CAUSE_EN to add the err_cause
// output (0 ok, 1 size, 2 rxer, 3 truncation, 4 FCS), loaded on every pkt_done.
// Streaming contract: pay_valid is a one-cycle strobe with no ready; the
// consumer must take pay_data in every cycle pay_valid is 1.
module rx_packet_parser #(
  parameter int                SFD_BYTES     = 4,
  parameter logic [63:0]       C_SFD         = 64'h5544557F,
  parameter logic [15:0]       C_PACKET_TYPE = 16'h1234,
  parameter logic [7:0]        C_SIZE_MIN    = 8'h08,
  parameter logic [7:0]        C_SIZE_MAX    = 8'hFF,
  parameter int                CNT_W         = 16,
  parameter logic [CNT_W-1:0]  CNT_MAX       = {CNT_W{1'b1}}
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic [7:0]       rxd_in,
  input  logic             rxdv_in,
  input  logic             rxer_in,
  output logic [7:0]       pay_data,
  output logic             pay_valid,
  output logic             pay_last,
  output logic             pkt_done,
  output logic             pkt_ok,
  output logic [CNT_W-1:0] stat_packet_vld_cnt,
  output logic [CNT_W-1:0] stat_packet_err_cnt,
  output logic [CNT_W-1:0] stat_packet_drop_cnt,
  output logic [2:0]       state_dbg
`ifdef RX_PACKET_PARSER_ERR_CAUSE_EN
  ,
  output logic [2:0]       err_cause
`endif
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SFD     = 3'd1;
  localparam logic [2:0] S_TYPE    = 3'd2;
  localparam logic [2:0] S_SIZE    = 3'd3;
  localparam logic [2:0] S_PAYLOAD = 3'd4;
  localparam logic [2:0] S_FCS     = 3'd5;
  localparam logic [2:0] S_WAIT    = 3'd6;

  localparam logic [2:0] C_OK    = 3'd0;
  localparam logic [2:0] C_SIZE  = 3'd1;
  localparam logic [2:0] C_RXER  = 3'd2;
  localparam logic [2:0] C_TRUNC = 3'd3;
  localparam logic [2:0] C_FCS   = 3'd4;

  // Selects the low SFD_BYTES bytes of a 64-bit word.
  localparam logic [63:0] SFD_MASK = 64'hFFFF_FFFF_FFFF_FFFF >> (64 - 8 * SFD_BYTES);
  localparam logic [3:0]  SFD_LAST = 4'(SFD_BYTES - 1);

  logic [2:0]  state, state_n;
  logic [55:0] sfd_sr, sfd_sr_n;
  logic [63:0] sfd_word;
  logic [3:0]  idx, idx_n;
  logic [7:0]  type_hi, type_hi_n;
  logic [7:0]  len, len_n;
  logic [7:0]  pay_cnt, pay_cnt_n, pay_cnt_inc;
  logic [7:0]  csum, csum_n, csum_add;
  logic [7:0]  pay_data_n;
  logic        pay_valid_n, pay_last_n, done_n, ok_n;
  logic [2:0]  cause_n;
  logic        vld_inc, err_inc, drop_inc;
  logic        size_bad;

  assign sfd_word    = {sfd_sr, rxd_in};
  assign csum_add    = csum + rxd_in;
  assign pay_cnt_inc = pay_cnt + 8'd1;
  assign size_bad    = ({1'b0, rxd_in} < {1'b0, C_SIZE_MIN}) ||
                       ({1'b0, rxd_in} > {1'b0, C_SIZE_MAX});
  assign state_dbg   = state;

  // Next-state, datapath and event decode for the framing FSM.
  always_comb begin
    state_n     = state;
    sfd_sr_n    = sfd_sr;
    idx_n       = idx;
    type_hi_n   = type_hi;
    len_n       = len;
    pay_cnt_n   = pay_cnt;
    csum_n      = csum;
    pay_data_n  = pay_data;
    pay_valid_n = 1'b0;
    pay_last_n  = 1'b0;
    done_n      = 1'b0;
    ok_n        = 1'b0;
    cause_n     = C_OK;
    vld_inc     = 1'b0;
    err_inc     = 1'b0;
    drop_inc    = 1'b0;

    case (state)
      S_IDLE: begin
        if (rxdv_in) begin
          sfd_sr_n = 56'(rxd_in);
          idx_n    = 4'd1;
          csum_n   = 8'd0;
          if (SFD_BYTES == 1) begin
            idx_n   = 4'd0;
            state_n = ((sfd_word & SFD_MASK) == (C_SFD & SFD_MASK)) ? S_TYPE : S_WAIT;
          end else begin
            state_n = S_SFD;
          end
        end
      end

      S_SFD: begin
        if (!rxdv_in) begin
          state_n = S_IDLE;
        end else if (rxer_in) begin
          done_n = 1'b1; err_inc = 1'b1; cause_n = C_RXER; state_n = S_WAIT;
        end else begin
          sfd_sr_n = sfd_word[55:0];
          idx_n    = idx + 4'd1;
          if (idx == SFD_LAST) begin
            idx_n   = 4'd0;
            state_n = ((sfd_word & SFD_MASK) == (C_SFD & SFD_MASK)) ? S_TYPE : S_WAIT;
          end
        end
      end

      S_TYPE: begin
        if (!rxdv_in) begin
          done_n = 1'b1; err_inc = 1'b1; cause_n = C_TRUNC; state_n = S_IDLE;
        end else if (rxer_in) begin
          done_n = 1'b1; err_inc = 1'b1; cause_n = C_RXER; state_n = S_WAIT;
        end else begin
          csum_n = csum_add;
          if (idx == 4'd0) begin
            type_hi_n = rxd_in;
            idx_n     = 4'd1;
          end else if ({type_hi, rxd_in} == C_PACKET_TYPE) begin
            state_n = S_SIZE;
          end else begin
            drop_inc = 1'b1;
            state_n  = S_WAIT;
          end
        end
      end

      S_SIZE: begin
        if (!rxdv_in) begin
          done_n = 1'b1; err_inc = 1'b1; cause_n = C_TRUNC; state_n = S_IDLE;
        end else if (rxer_in) begin
          done_n = 1'b1; err_inc = 1'b1; cause_n = C_RXER; state_n = S_WAIT;
        end else if (size_bad) begin
          done_n = 1'b1; err_inc = 1'b1; cause_n = C_SIZE; state_n = S_WAIT;
        end else begin
          len_n     = rxd_in;
          csum_n    = csum_add;
          pay_cnt_n = 8'd0;
          // A zero-length payload (only possible when C_SIZE_MIN is 0) skips straight to FCS.
          state_n   = (rxd_in == 8'd0) ? S_FCS : S_PAYLOAD;
        end
      end

      S_PAYLOAD: begin
        if (!rxdv_in) begin
          done_n = 1'b1; err_inc = 1'b1; cause_n = C_TRUNC; state_n = S_IDLE;
        end else if (rxer_in) begin
          done_n = 1'b1; err_inc = 1'b1; cause_n = C_RXER; state_n = S_WAIT;
        end else begin
          pay_data_n  = rxd_in;
          pay_valid_n = 1'b1;
          csum_n      = csum_add;
          pay_cnt_n   = pay_cnt_inc;
          if (pay_cnt_inc == len) begin
            pay_last_n = 1'b1;
            state_n    = S_FCS;
          end
        end
      end

      S_FCS: begin
        if (!rxdv_in) begin
          done_n = 1'b1; err_inc = 1'b1; cause_n = C_TRUNC; state_n = S_IDLE;
        end else if (rxer_in) begin
          done_n = 1'b1; err_inc = 1'b1; cause_n = C_RXER; state_n = S_WAIT;
        end else if (csum_add == 8'd0) begin
          done_n = 1'b1; ok_n = 1'b1; vld_inc = 1'b1; state_n = S_WAIT;
        end else begin
          done_n = 1'b1; err_inc = 1'b1; cause_n = C_FCS; state_n = S_WAIT;
        end
      end

      S_WAIT: begin
        if (!rxdv_in) state_n = S_IDLE;
      end

      default: state_n = S_IDLE;
    endcase
  end

  // FSM and datapath registers; reset drops any packet in flight.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state     <= S_IDLE;
      sfd_sr    <= '0;
      idx       <= '0;
      type_hi   <= '0;
      len       <= '0;
      pay_cnt   <= '0;
      csum      <= '0;
      pay_data  <= '0;
      pay_valid <= 1'b0;
      pay_last  <= 1'b0;
      pkt_done  <= 1'b0;
      pkt_ok    <= 1'b0;
    end else begin
      state     <= state_n;
      sfd_sr    <= sfd_sr_n;
      idx       <= idx_n;
      type_hi   <= type_hi_n;
      len       <= len_n;
      pay_cnt   <= pay_cnt_n;
      csum      <= csum_n;
      pay_data  <= pay_data_n;
      pay_valid <= pay_valid_n;
      pay_last  <= pay_last_n;
      pkt_done  <= done_n;
      pkt_ok    <= ok_n;
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      stat_packet_vld_cnt  <= '0;
      stat_packet_err_cnt  <= '0;
      stat_packet_drop_cnt <= '0;
    end else begin
      if (vld_inc && stat_packet_vld_cnt != CNT_MAX)
        stat_packet_vld_cnt <= stat_packet_vld_cnt + 1'b1;
      if (err_inc && stat_packet_err_cnt != CNT_MAX)
        stat_packet_err_cnt <= stat_packet_err_cnt + 1'b1;
      if (drop_inc && stat_packet_drop_cnt != CNT_MAX)
        stat_packet_drop_cnt <= stat_packet_drop_cnt + 1'b1;
    end
  end

`ifdef RX_PACKET_PARSER_ERR_CAUSE_EN
  // Cause of the latest pkt_done, held until the next one.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)   err_cause <= C_OK;
    else if (done_n) err_cause <= cause_n;
  end
`else
  logic unused_cause;
  assign unused_cause = ^cause_n;
`endif

endmodule
